// File: rtl/reg_window_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reg_window_fifo
// Purpose  : Circular register buffer that accepts IN_PIX-pixel words and
//            presents a sliding WIN-pixel window consumed by a variable stride.
// Revision : 1.0 - initial release
// ============================================================================
module reg_window_fifo #(
  parameter int PIX_W  = 16,
  parameter int IN_PIX = 8,
  parameter int DEPTH  = 16,
  parameter int WIN    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      row_done,
  input  logic                      pad_left,
  input  logic [1:0]                stride,
  input  logic [IN_PIX*PIX_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIN*PIX_W-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  localparam logic [c_CW-1:0] c_FREE_MAX = c_CW'(DEPTH - IN_PIX);
  localparam logic [c_CW-1:0] c_IN_PIX   = c_CW'(IN_PIX);
  localparam logic [c_CW-1:0] c_WIN      = c_CW'(WIN);

  if (DEPTH < IN_PIX + WIN) begin : g_bad_depth
    $error("reg_window_fifo: DEPTH must be at least IN_PIX + WIN");
  end
  if (WIN < 3) begin : g_bad_win
    $error("reg_window_fifo: WIN must be at least 3");
  end

  logic [DEPTH-1:0][PIX_W-1:0] r_mem;
  logic [c_PW-1:0]             r_rd;
  logic [c_PW-1:0]             r_wr;
  logic [c_CW-1:0]             r_count;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_flush;
  logic [1:0]                  w_stride;
  logic [c_CW-1:0]             w_count_next;

  // Pointer advance modulo DEPTH; inc is always below DEPTH so one subtract suffices.
  function automatic logic [c_PW-1:0] wrap_add(input logic [c_PW-1:0] ptr,
                                               input logic [c_PW:0]   inc);
    logic [c_PW:0] sum;
    sum = {1'b0, ptr} + inc;
    if (sum >= (c_PW+1)'(DEPTH)) begin
      sum = sum - (c_PW+1)'(DEPTH);
    end
    return sum[c_PW-1:0];
  endfunction

  assign in_ready  = (r_count <= c_FREE_MAX);
  assign out_valid = (r_count >= c_WIN);
  assign count     = r_count;

  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;
  assign w_flush  = start | row_done;
  assign w_stride = (stride == 2'd0) ? 2'd1 : stride;

  always_comb begin
    w_count_next = r_count;
    if (w_push) begin
      w_count_next = w_count_next + c_IN_PIX;
    end
    if (w_pop) begin
      w_count_next = w_count_next - c_CW'(w_stride);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      // Optional left pad is the already-zeroed entry 0 counted as stored.
      r_mem   <= '0;
      r_rd    <= '0;
      r_wr    <= pad_left ? c_PW'(1) : '0;
      r_count <= pad_left ? c_CW'(1) : '0;
    end else begin
      if (w_push) begin
        for (int i = 0; i < IN_PIX; i++) begin
          r_mem[wrap_add(r_wr, (c_PW+1)'(i))] <= in_data[i*PIX_W +: PIX_W];
        end
        r_wr <= wrap_add(r_wr, (c_PW+1)'(IN_PIX));
      end
      if (w_pop) begin
        r_rd <= wrap_add(r_rd, (c_PW+1)'(w_stride));
      end
      r_count <= w_count_next;
    end
  end

  for (genvar gi = 0; gi < WIN; gi++) begin : g_win
    assign out_data[gi*PIX_W +: PIX_W] = r_mem[wrap_add(r_rd, (c_PW+1)'(gi))];
  end

endmodule
`default_nettype wire
